// File: rtl/line_sample_reader_pkg.sv
// Shared constants and FSM encoding for the interpolation input-line reader.
package line_sample_reader_pkg;

  localparam int unsigned SAMPLE_W        = 8;
  localparam int unsigned NUM_SAMPLES     = 9;
  localparam int unsigned LINE_W          = SAMPLE_W * NUM_SAMPLES;
  localparam int unsigned LINES_PER_BLOCK = 8;

  localparam int unsigned SAMPLE_IDX_W = $clog2(NUM_SAMPLES);
  localparam int unsigned LINE_IDX_W   = $clog2(LINES_PER_BLOCK);

  localparam logic [SAMPLE_IDX_W-1:0] LAST_SAMPLE_IDX = SAMPLE_IDX_W'(NUM_SAMPLES - 1);
  localparam logic [LINE_IDX_W-1:0]   LAST_LINE_IDX   = LINE_IDX_W'(LINES_PER_BLOCK - 1);

  typedef logic [LINE_W-1:0]   line_t;
  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LINE = 2'd1,
    STREAM    = 2'd2,
    DONE      = 2'd3
  } state_e;

endpackage

// File: rtl/line_shift_reg.sv
// Line holding register: parallel load of a full line, then shifts one
// sample towards the head per advance; the head is the current sample.
module line_shift_reg
  import line_sample_reader_pkg::*;
(
  input  logic    CLK,
  input  logic    RST_ASYNC_N,
  input  logic    load,
  input  logic    shift,
  input  line_t   line_in,
  output sample_t head
);

  line_t shreg;

  // Load has priority: a back-to-back line replaces the exhausted one.
  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= line_in;
    end else if (shift) begin
      shreg <= {shreg[LINE_W-SAMPLE_W-1:0], {SAMPLE_W{1'b0}}};
    end
  end

  assign head = shreg[LINE_W-1 -: SAMPLE_W];

endmodule

// File: rtl/line_sample_reader.sv
// Consumes lines from the input-line register and streams their samples,
// sample 0 first, for a fixed number of lines per START.
module line_sample_reader
  import line_sample_reader_pkg::*;
(
  input  logic                    CLK,
  input  logic                    RST_ASYNC_N,
  input  logic                    START,
  input  logic                    LINE_VALID,
  input  logic [LINE_W-1:0]       LINE_IN,
  output logic                    LINE_READ,
  output logic [SAMPLE_W-1:0]     SAMPLE_OUT,
  output logic                    SAMPLE_VALID,
  input  logic                    SAMPLE_READY,
  output logic [SAMPLE_IDX_W-1:0] SAMPLE_IDX,
  output logic [LINE_IDX_W-1:0]   LINE_IDX,
  output logic                    LAST_SAMPLE,
  output logic                    BUSY,
  output logic                    BLOCK_DONE
);

  state_e                  state_q, state_d;
  logic [SAMPLE_IDX_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [LINE_IDX_W-1:0]   line_cnt_q, line_cnt_d;
  logic                    block_done_q, block_done_d;
  logic                    load, shift, xfer;
  logic                    line_last_sample, block_last_line;

  line_shift_reg u_line_shift_reg (
    .CLK         (CLK),
    .RST_ASYNC_N (RST_ASYNC_N),
    .load        (load),
    .shift       (shift),
    .line_in     (LINE_IN),
    .head        (SAMPLE_OUT)
  );

  assign SAMPLE_VALID     = (state_q == STREAM);
  assign xfer             = SAMPLE_VALID && SAMPLE_READY;
  assign line_last_sample = (sample_cnt_q == LAST_SAMPLE_IDX);
  assign block_last_line  = (line_cnt_q == LAST_LINE_IDX);

  // State and counter registers.
  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      state_q      <= IDLE;
      sample_cnt_q <= '0;
      line_cnt_q   <= '0;
      block_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      line_cnt_q   <= line_cnt_d;
      block_done_q <= block_done_d;
    end
  end

  // Next state, counter updates and line-register handshake.
  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    line_cnt_d   = line_cnt_q;
    block_done_d = 1'b0;
    load         = 1'b0;
    shift        = 1'b0;
    LINE_READ    = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          state_d      = WAIT_LINE;
          line_cnt_d   = '0;
          sample_cnt_d = '0;
        end
      end
      WAIT_LINE: begin
        if (LINE_VALID) begin
          load         = 1'b1;
          LINE_READ    = 1'b1;
          sample_cnt_d = '0;
          state_d      = STREAM;
        end
      end
      STREAM: begin
        if (xfer) begin
          if (!line_last_sample) begin
            shift        = 1'b1;
            sample_cnt_d = sample_cnt_q + SAMPLE_IDX_W'(1);
          end else if (block_last_line) begin
            state_d      = DONE;
            block_done_d = 1'b1;
          end else begin
            line_cnt_d = line_cnt_q + LINE_IDX_W'(1);
            // Take the next line in the same cycle to avoid a bubble.
            if (LINE_VALID) begin
              load         = 1'b1;
              LINE_READ    = 1'b1;
              sample_cnt_d = '0;
            end else begin
              state_d = WAIT_LINE;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign SAMPLE_IDX  = sample_cnt_q;
  assign LINE_IDX    = line_cnt_q;
  assign LAST_SAMPLE = SAMPLE_VALID && line_last_sample && block_last_line;
  assign BUSY        = (state_q != IDLE);
  assign BLOCK_DONE  = block_done_q;

endmodule

// File: tb/tb_line_sample_reader.sv
// Self-checking bench for line_sample_reader: directed scenarios plus a
// randomized block run against a line/sample queue reference model.
module tb_line_sample_reader;

  localparam int NS = 9;
  localparam int NL = 8;

  logic        CLK = 1'b0;
  logic        RST_ASYNC_N;
  logic        START;
  logic        LINE_VALID;
  logic [71:0] LINE_IN;
  logic        LINE_READ;
  logic [7:0]  SAMPLE_OUT;
  logic        SAMPLE_VALID;
  logic        SAMPLE_READY;
  logic [3:0]  SAMPLE_IDX;
  logic [2:0]  LINE_IDX;
  logic        LAST_SAMPLE;
  logic        BUSY;
  logic        BLOCK_DONE;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  line_sample_reader dut (
    .CLK          (CLK),
    .RST_ASYNC_N  (RST_ASYNC_N),
    .START        (START),
    .LINE_VALID   (LINE_VALID),
    .LINE_IN      (LINE_IN),
    .LINE_READ    (LINE_READ),
    .SAMPLE_OUT   (SAMPLE_OUT),
    .SAMPLE_VALID (SAMPLE_VALID),
    .SAMPLE_READY (SAMPLE_READY),
    .SAMPLE_IDX   (SAMPLE_IDX),
    .LINE_IDX     (LINE_IDX),
    .LAST_SAMPLE  (LAST_SAMPLE),
    .BUSY         (BUSY),
    .BLOCK_DONE   (BLOCK_DONE)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_ASYNC_N  = 1'b0;
    START        = 1'b0;
    LINE_VALID   = 1'b0;
    SAMPLE_READY = 1'b0;
    LINE_IN      = '0;
    step();
    step();
    RST_ASYNC_N = 1'b1;
  endtask

  function automatic logic [71:0] rand_line();
    return {8'($urandom), $urandom, $urandom};
  endfunction

  function automatic logic [7:0] sample_of(input logic [71:0] line, input int k);
    return 8'(line >> (8 * (NS - 1 - k)));
  endfunction

  task automatic test_reset();
    RST_ASYNC_N  = 1'b0;
    START        = 1'b1;
    LINE_VALID   = 1'b1;
    SAMPLE_READY = 1'b1;
    LINE_IN      = 72'hFFEEDDCCBBAA998877;
    #3;
    checks++; if (LINE_READ !== 1'b0)    begin errors++; $display("FAIL reset line_read: got %b exp 0", LINE_READ); end
    checks++; if (SAMPLE_OUT !== 8'h00)  begin errors++; $display("FAIL reset sample_out: got %h exp 00", SAMPLE_OUT); end
    checks++; if (SAMPLE_VALID !== 1'b0) begin errors++; $display("FAIL reset sample_valid: got %b exp 0", SAMPLE_VALID); end
    checks++; if (SAMPLE_IDX !== 4'd0)   begin errors++; $display("FAIL reset sample_idx: got %0d exp 0", SAMPLE_IDX); end
    checks++; if (LINE_IDX !== 3'd0)     begin errors++; $display("FAIL reset line_idx: got %0d exp 0", LINE_IDX); end
    checks++; if (LAST_SAMPLE !== 1'b0)  begin errors++; $display("FAIL reset last_sample: got %b exp 0", LAST_SAMPLE); end
    checks++; if (BUSY !== 1'b0)         begin errors++; $display("FAIL reset busy: got %b exp 0", BUSY); end
    checks++; if (BLOCK_DONE !== 1'b0)   begin errors++; $display("FAIL reset block_done: got %b exp 0", BLOCK_DONE); end
    step();
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset busy_held: got %b exp 0", BUSY); end
    START = 1'b0; LINE_VALID = 1'b0;
    RST_ASYNC_N = 1'b1;
    step();
  endtask

  task automatic test_basic_line();
    int reads;
    do_reset();
    LINE_IN      = 72'h010203040506070809;
    SAMPLE_READY = 1'b1;
    START        = 1'b1;
    step();
    START = 1'b0;
    checks++; if (BUSY !== 1'b1 || SAMPLE_VALID !== 1'b0) begin errors++; $display("FAIL basic wait_line: got busy %b valid %b exp 1 0", BUSY, SAMPLE_VALID); end
    LINE_VALID = 1'b1;
    #1;
    reads = int'(LINE_READ);
    step();
    LINE_VALID = 1'b0;
    for (int k = 0; k < NS; k++) begin
      #1;
      checks++; if (SAMPLE_VALID !== 1'b1)  begin errors++; $display("FAIL basic valid[%0d]: got %b exp 1", k, SAMPLE_VALID); end
      checks++; if (SAMPLE_OUT !== 8'(k + 1)) begin errors++; $display("FAIL basic sample_out[%0d]: got %h exp %h", k, SAMPLE_OUT, 8'(k + 1)); end
      checks++; if (SAMPLE_IDX !== 4'(k))    begin errors++; $display("FAIL basic sample_idx[%0d]: got %0d exp %0d", k, SAMPLE_IDX, k); end
      reads += int'(LINE_READ);
      step();
    end
    checks++; if (reads !== 1) begin errors++; $display("FAIL basic line_read_count: got %0d exp 1", reads); end
    checks++; if (SAMPLE_VALID !== 1'b0 || LINE_IDX !== 3'd1) begin errors++; $display("FAIL basic after_line: got valid %b line_idx %0d exp 0 1", SAMPLE_VALID, LINE_IDX); end
  endtask

  task automatic test_full_block();
    logic [71:0] lines[NL];
    int n_read = 0;
    int reads  = 0;
    int dones  = 0;
    int x;
    foreach (lines[i]) lines[i] = rand_line();
    do_reset();
    SAMPLE_READY = 1'b1;
    LINE_VALID   = 1'b1;
    START        = 1'b1;
    step();
    START = 1'b0;
    for (int c = 0; c <= 74; c++) begin
      LINE_IN = lines[n_read < NL ? n_read : NL - 1];
      #1;
      if (c >= 1 && c <= 72) begin
        x = c - 1;
        checks++; if (SAMPLE_VALID !== 1'b1) begin errors++; $display("FAIL full valid[%0d]: got %b exp 1", x, SAMPLE_VALID); end
        checks++; if (SAMPLE_OUT !== sample_of(lines[x / NS], x % NS)) begin errors++; $display("FAIL full sample_out[%0d]: got %h exp %h", x, SAMPLE_OUT, sample_of(lines[x / NS], x % NS)); end
        checks++; if (SAMPLE_IDX !== 4'(x % NS) || LINE_IDX !== 3'(x / NS)) begin errors++; $display("FAIL full idx[%0d]: got %0d/%0d exp %0d/%0d", x, LINE_IDX, SAMPLE_IDX, x / NS, x % NS); end
        checks++; if (LAST_SAMPLE !== (c == 72)) begin errors++; $display("FAIL full last_sample[%0d]: got %b exp %b", x, LAST_SAMPLE, c == 72); end
      end
      if (c == 73) begin
        checks++; if (BLOCK_DONE !== 1'b1 || BUSY !== 1'b1) begin errors++; $display("FAIL full done_cycle: got done %b busy %b exp 1 1", BLOCK_DONE, BUSY); end
      end
      if (c == 74) begin
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL full busy_fall: got %b exp 0", BUSY); end
      end
      reads += int'(LINE_READ);
      dones += int'(BLOCK_DONE);
      if (LINE_READ) n_read++;
      step();
    end
    checks++; if (reads !== NL) begin errors++; $display("FAIL full line_read_count: got %0d exp %0d", reads, NL); end
    checks++; if (dones !== 1)  begin errors++; $display("FAIL full block_done_count: got %0d exp 1", dones); end
  endtask

  // ready_mode: 0 always, 1 pattern 1,0,0, 2 random.
  // lv_mode: 0 always, 1 random, 2 five-cycle starvation after line 0.
  task automatic test_stream(input string name, input int ready_mode, input int lv_mode, input bit spurious);
    logic [71:0] lines[NL];
    int          q_l[$];
    int          q_s[$];
    logic [7:0]  q_d[$];
    int taken = 0, cyc = 0, starve = 0;
    bit busy = 0, done_pend = 0, finished = 0;
    bit xfer, exp_lr, last_x, start_now;
    foreach (lines[i]) lines[i] = rand_line();
    do_reset();
    while (!finished && cyc < 800) begin
      START = (cyc == 0) || (spurious && $urandom_range(0, 3) == 0);
      case (ready_mode)
        0:       SAMPLE_READY = 1'b1;
        1:       SAMPLE_READY = (cyc % 3 == 0);
        default: SAMPLE_READY = 1'($urandom_range(0, 1));
      endcase
      case (lv_mode)
        0:       LINE_VALID = 1'b1;
        1:       LINE_VALID = 1'($urandom_range(0, 1));
        default: LINE_VALID = !(taken == 1 && (q_s.size() > 0 || starve < 5));
      endcase
      LINE_IN = lines[taken < NL ? taken : 0];
      #1;
      xfer   = (q_s.size() > 0) && SAMPLE_READY;
      exp_lr = busy && !done_pend && taken < NL && LINE_VALID &&
               (q_s.size() == 0 || (q_s.size() == 1 && xfer));
      checks++; if (SAMPLE_VALID !== (q_s.size() > 0)) begin errors++; $display("FAIL %s valid@%0d: got %b exp %b", name, cyc, SAMPLE_VALID, q_s.size() > 0); end
      checks++; if (LINE_READ !== exp_lr)  begin errors++; $display("FAIL %s line_read@%0d: got %b exp %b", name, cyc, LINE_READ, exp_lr); end
      checks++; if (BUSY !== busy)         begin errors++; $display("FAIL %s busy@%0d: got %b exp %b", name, cyc, BUSY, busy); end
      checks++; if (BLOCK_DONE !== done_pend) begin errors++; $display("FAIL %s block_done@%0d: got %b exp %b", name, cyc, BLOCK_DONE, done_pend); end
      if (q_s.size() > 0) begin
        checks++; if (SAMPLE_OUT !== q_d[0]) begin errors++; $display("FAIL %s sample_out@%0d: got %h exp %h", name, cyc, SAMPLE_OUT, q_d[0]); end
        checks++; if (SAMPLE_IDX !== 4'(q_s[0]) || LINE_IDX !== 3'(q_l[0])) begin errors++; $display("FAIL %s idx@%0d: got %0d/%0d exp %0d/%0d", name, cyc, LINE_IDX, SAMPLE_IDX, q_l[0], q_s[0]); end
        checks++; if (LAST_SAMPLE !== (q_s[0] == NS - 1 && q_l[0] == NL - 1)) begin errors++; $display("FAIL %s last_sample@%0d: got %b", name, cyc, LAST_SAMPLE); end
      end
      if (lv_mode == 2 && busy && q_s.size() == 0 && taken == 1) begin
        checks++; if (LINE_IDX !== 3'd1) begin errors++; $display("FAIL %s starve_line_idx@%0d: got %0d exp 1", name, cyc, LINE_IDX); end
      end
      last_x    = xfer && q_s[0] == NS - 1 && q_l[0] == NL - 1;
      start_now = !busy && START;
      if (taken == 1 && q_s.size() == 0) starve++;
      if (done_pend) begin
        busy = 0; done_pend = 0; finished = 1;
      end
      if (xfer) begin
        void'(q_l.pop_front()); void'(q_s.pop_front()); void'(q_d.pop_front());
      end
      if (exp_lr) begin
        for (int k = 0; k < NS; k++) begin
          q_l.push_back(taken); q_s.push_back(k); q_d.push_back(sample_of(lines[taken], k));
        end
        taken++;
      end
      if (last_x) done_pend = 1;
      if (start_now) begin
        busy = 1; taken = 0;
      end
      step();
      cyc++;
    end
    START = 1'b0; LINE_VALID = 1'b0;
    checks++; if (!finished) begin errors++; $display("FAIL %s timeout: got no block end after %0d cycles exp block end", name, cyc); end
    #1;
    checks++; if (BUSY !== 1'b0 || SAMPLE_VALID !== 1'b0) begin errors++; $display("FAIL %s idle_after: got busy %b valid %b exp 0 0", name, BUSY, SAMPLE_VALID); end
    step();
  endtask

  task automatic test_reset_mid_block();
    logic [71:0] l0;
    do_reset();
    l0           = rand_line();
    LINE_IN      = l0;
    SAMPLE_READY = 1'b1;
    LINE_VALID   = 1'b1;
    START        = 1'b1;
    step();
    START = 1'b0;
    for (int c = 0; c < 1 + 3 * NS + 4; c++) step();
    #1;
    checks++; if (LINE_IDX !== 3'd3 || SAMPLE_IDX !== 4'd4 || SAMPLE_VALID !== 1'b1) begin errors++; $display("FAIL midrst position: got %0d/%0d valid %b exp 3/4 1", LINE_IDX, SAMPLE_IDX, SAMPLE_VALID); end
    RST_ASYNC_N = 1'b0;
    #1;
    checks++; if (SAMPLE_VALID !== 1'b0 || LINE_READ !== 1'b0 || BUSY !== 1'b0 || SAMPLE_OUT !== 8'h00) begin errors++; $display("FAIL midrst async_clear: got valid %b read %b busy %b out %h exp 0 0 0 00", SAMPLE_VALID, LINE_READ, BUSY, SAMPLE_OUT); end
    checks++; if (SAMPLE_IDX !== 4'd0 || LINE_IDX !== 3'd0 || LAST_SAMPLE !== 1'b0 || BLOCK_DONE !== 1'b0) begin errors++; $display("FAIL midrst idx_clear: got %0d/%0d last %b done %b exp 0/0 0 0", LINE_IDX, SAMPLE_IDX, LAST_SAMPLE, BLOCK_DONE); end
    step();
    checks++; if (LINE_READ !== 1'b0) begin errors++; $display("FAIL midrst no_read: got %b exp 0", LINE_READ); end
    RST_ASYNC_N = 1'b1;
    step();
    START = 1'b1;
    step();
    START = 1'b0;
    #1;
    checks++; if (LINE_IDX !== 3'd0 || SAMPLE_IDX !== 4'd0 || LINE_READ !== 1'b1) begin errors++; $display("FAIL midrst restart: got %0d/%0d read %b exp 0/0 1", LINE_IDX, SAMPLE_IDX, LINE_READ); end
    step();
    checks++; if (SAMPLE_VALID !== 1'b1 || SAMPLE_OUT !== sample_of(l0, 0) || SAMPLE_IDX !== 4'd0) begin errors++; $display("FAIL midrst first_sample: got valid %b out %h idx %0d exp 1 %h 0", SAMPLE_VALID, SAMPLE_OUT, SAMPLE_IDX, sample_of(l0, 0)); end
    do_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running exp finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_line();
    test_full_block();
    test_stream("backpressure", 1, 0, 1'b0);
    test_stream("starvation", 0, 2, 1'b0);
    test_stream("spurious_start", 0, 0, 1'b1);
    test_stream("random", 2, 1, 1'b1);
    test_stream("random_starve", 2, 2, 1'b1);
    test_reset_mid_block();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
